// File: rtl/ov7670_config_seq.sv
// OV7670 register-table sequencer: walks a synchronous ROM of {reg, value}
// entries and hands each one to an SCCB/I2C write engine, honouring delay and end markers.
module ov7670_config_seq #(
  parameter logic [7:0]  DEVICE_ID    = 8'h42,
  parameter logic [23:0] DELAY_CYCLES = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        send,
  input  logic        taken,
  output logic [7:0]  id,
  output logic [7:0]  reg_addr,
  output logic [7:0]  value,
  output logic        busy,
  output logic        done,
  output logic [7:0]  write_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, DELAY, DONE} state_e;

  localparam logic [15:0] END_MARK = 16'hFFFF;
  localparam logic [15:0] DLY_MARK = 16'hFFF0;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  val_q, val_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [23:0] cnt_q, cnt_d;
  logic        send_q, send_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    val_d   = val_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (rom_data == END_MARK) begin
          state_d = DONE;
        end else if (rom_data == DLY_MARK) begin
          state_d = DELAY;
          cnt_d   = DELAY_CYCLES - 24'd1;
        end else begin
          state_d = SEND;
          reg_d   = rom_data[15:8];
          val_d   = rom_data[7:0];
        end
      end
      SEND: begin
        if (taken) begin
          wcnt_d = (wcnt_q == 8'hFF) ? 8'hFF : wcnt_q + 8'd1;
          if (addr_q == 8'hFF) state_d = DONE;
          else begin
            addr_d  = addr_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      DELAY: begin
        if (cnt_q == 24'd0) begin
          if (addr_q == 8'hFF) state_d = DONE;
          else begin
            addr_d  = addr_q + 8'd1;
            state_d = FETCH;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: ;
    endcase
    // start overrides everything, including a taken on the same edge
    if (start) begin
      state_d = FETCH;
      addr_d  = 8'd0;
      wcnt_d  = 8'd0;
    end
    send_d = (state_d == SEND);
    busy_d = (state_d == FETCH) || (state_d == DECODE) || (state_d == SEND) || (state_d == DELAY);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      reg_q   <= 8'd0;
      val_q   <= 8'd0;
      wcnt_q  <= 8'd0;
      cnt_q   <= 24'd0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr    = addr_q;
  assign send        = send_q;
  assign id          = DEVICE_ID;
  assign reg_addr    = reg_q;
  assign value       = val_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign write_count = wcnt_q;

endmodule
